// File: rtl/sram_pkt_reader.sv
// Burst read client for the dual-port packet SRAM: takes a (start, length)
// request, streams the words out on a valid/ready interface with a last flag,
// and keeps at most two words buffered so backpressure never loses data.
module sram_pkt_reader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 11
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;   // next address to issue
  logic [LEN_W-1:0]    rem_q, rem_d;     // reads still to issue
  logic [LEN_W-1:0]    len_q, len_d;     // burst length
  logic [LEN_W-1:0]    dlv_q, dlv_d;     // words delivered so far
  logic                infl_q;           // read issued last cycle, data arrives now
  logic [DATA_W-1:0]   mem_q [2];
  logic                wptr_q, rptr_q;
  logic [1:0]          cnt_q;

  logic                accept, pop;
  logic [2:0]          lvl;

  assign accept = req_valid && (state_q == S_IDLE);
  assign pop    = out_valid && out_ready;

  // Occupancy the FIFO will have once this cycle's in-flight word lands and
  // this cycle's pop leaves; a new read is only safe while it stays below 2.
  // Using the same-cycle pop is what allows back-to-back reads at full rate.
  assign lvl = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = (req_len != '0) ? S_READ : S_DONE;
      S_READ:  if (rd_en && rem_q == LEN_W'(1)) state_d = S_DRAIN;
      S_DRAIN: if (pop && out_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: handshake/status flags and read issue gating
  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    rd_en     = (state_q == S_READ) && (rem_q != '0) && (lvl < 3'd2);
  end

  // Burst bookkeeping: address, reads remaining, words delivered
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    len_d  = len_q;
    dlv_d  = dlv_q;
    if (accept) begin
      addr_d = req_addr;
      rem_d  = req_len;
      len_d  = req_len;
      dlv_d  = '0;
    end else begin
      if (rd_en) begin
        addr_d = addr_q + ADDR_W'(1);   // wraps at the top of the SRAM
        rem_d  = rem_q - LEN_W'(1);
      end
      if (pop) dlv_d = dlv_q + LEN_W'(1);
    end
  end

  // Bookkeeping registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
      len_q  <= '0;
      dlv_q  <= '0;
      infl_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      len_q  <= len_d;
      dlv_q  <= dlv_d;
      infl_q <= rd_en;
    end
  end

  // Two-entry output FIFO; only captures rd_data the cycle after a read
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (infl_q) begin
        mem_q[wptr_q] <= rd_data;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

  assign rd_addr   = addr_q;
  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_q[rptr_q];
  assign out_last  = out_valid && (dlv_q == len_q - LEN_W'(1));

endmodule
